// File: rtl/pipeline_if_id_hazard.sv
// IF/ID pipeline register with hazard control: branch flush, precise interrupt
// acceptance, load-use stall, jump slot discard, and saturating perf counters.
module pipeline_if_id_hazard (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IF_PC,
   input  logic [31:0] IF_Instr,
   input  logic        ID_EX_MemRead,
   input  logic [4:0]  ID_EX_Rt,
   input  logic        EX_BranchTaken,
   input  logic        irq,
   output logic        PCWrite,
   output logic [31:0] IF_ID_PC,
   output logic [31:0] IF_ID_PCplus4,
   output logic [31:0] IF_ID_Instr,
   output logic        IF_ID_Valid,
   output logic        ID_EX_Flush,
   output logic        Int_Take,
   output logic [31:0] EPC,
   output logic [15:0] StallCnt,
   output logic [15:0] FlushCnt
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned CNTW   = 16;
   localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
   localparam logic [CNTW-1:0] CNT_MAX  = 16'hFFFF;

   typedef enum logic [2:0] {
      ACT_NORMAL,
      ACT_BRANCH,
      ACT_INT,
      ACT_STALL,
      ACT_JUMP
   } action_e;

   action_e          action;
   logic             irq_pending;
   logic             jump;
   logic             load_use;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [XLEN-1:0]  if_pcplus4;

   // Kernel-mode bit 31 is carried through untouched by the increment.
   assign if_pcplus4 = {IF_PC[31], IF_PC[30:0] + 31'd4};

   // Hazard detection and event priority resolution.
   always_comb begin
      opcode   = IF_ID_Instr[31:26];
      funct    = IF_ID_Instr[5:0];
      jump     = 1'b0;
      load_use = 1'b0;
      Int_Take = 1'b0;
      action   = ACT_NORMAL;

      jump = IF_ID_Valid &&
             ((opcode == 6'h02) || (opcode == 6'h03) ||
              ((opcode == 6'h00) && ((funct == 6'h08) || (funct == 6'h09))));

      load_use = IF_ID_Valid && ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                 ((ID_EX_Rt == IF_ID_Instr[25:21]) || (ID_EX_Rt == IF_ID_Instr[20:16]));

      Int_Take = irq_pending && IF_ID_Valid && !IF_ID_PC[31] && !EX_BranchTaken;

      if (EX_BranchTaken)  action = ACT_BRANCH;
      else if (Int_Take)   action = ACT_INT;
      else if (load_use)   action = ACT_STALL;
      else if (jump)       action = ACT_JUMP;
   end

   assign PCWrite     = (action != ACT_STALL);
   assign ID_EX_Flush = (action == ACT_BRANCH) || (action == ACT_INT) || (action == ACT_STALL);

   // IF/ID stage registers, interrupt bookkeeping and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         IF_ID_PC      <= RESET_PC;
         IF_ID_PCplus4 <= '0;
         IF_ID_Instr   <= '0;
         IF_ID_Valid   <= 1'b0;
         EPC           <= '0;
         irq_pending   <= 1'b0;
         StallCnt      <= '0;
         FlushCnt      <= '0;
      end else begin
         // A new request in the acceptance cycle must not be lost.
         irq_pending <= irq | (irq_pending & ~Int_Take);

         case (action)
            ACT_STALL: begin
               if (StallCnt != CNT_MAX) StallCnt <= StallCnt + CNTW'(1);
            end
            ACT_BRANCH, ACT_INT, ACT_JUMP: begin
               IF_ID_PC      <= '0;
               IF_ID_PCplus4 <= '0;
               IF_ID_Instr   <= '0;
               IF_ID_Valid   <= 1'b0;
               if (action == ACT_INT) EPC <= IF_ID_PC;
               if (FlushCnt != CNT_MAX) FlushCnt <= FlushCnt + CNTW'(1);
            end
            default: begin
               IF_ID_PC      <= IF_PC;
               IF_ID_PCplus4 <= if_pcplus4;
               IF_ID_Instr   <= IF_Instr;
               IF_ID_Valid   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_if_id_hazard.sv
// Directed scoreboard bench for pipeline_if_id_hazard: expected IF/ID contents are
// queued when a cycle is driven and compared after the following clock edge.
module tb_pipeline_if_id_hazard;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IF_PC, IF_Instr;
   logic        ID_EX_MemRead;
   logic [4:0]  ID_EX_Rt;
   logic        EX_BranchTaken, irq;
   logic        PCWrite, IF_ID_Valid, ID_EX_Flush, Int_Take;
   logic [31:0] IF_ID_PC, IF_ID_PCplus4, IF_ID_Instr, EPC;
   logic [15:0] StallCnt, FlushCnt;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic        valid;
      logic [31:0] epc;
      logic [15:0] stall;
      logic [15:0] flush;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] e_epc   = '0;
   logic [15:0] e_stall = '0;
   logic [15:0] e_flush = '0;

   pipeline_if_id_hazard dut (
      .clk(clk), .reset(reset), .IF_PC(IF_PC), .IF_Instr(IF_Instr),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
      .EX_BranchTaken(EX_BranchTaken), .irq(irq), .PCWrite(PCWrite),
      .IF_ID_PC(IF_ID_PC), .IF_ID_PCplus4(IF_ID_PCplus4), .IF_ID_Instr(IF_ID_Instr),
      .IF_ID_Valid(IF_ID_Valid), .ID_EX_Flush(ID_EX_Flush), .Int_Take(Int_Take),
      .EPC(EPC), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic comb(input logic pw, input logic fl, input logic it);
      #1;
      check("PCWrite", 32'(PCWrite), 32'(pw));
      check("ID_EX_Flush", 32'(ID_EX_Flush), 32'(fl));
      check("Int_Take", 32'(Int_Take), 32'(it));
   endtask

   task automatic nxt(input logic [31:0] pc, input logic [31:0] pc4,
                      input logic [31:0] instr, input logic valid);
      exp_t e;
      e.pc = pc; e.pc4 = pc4; e.instr = instr; e.valid = valid;
      e.epc = e_epc; e.stall = e_stall; e.flush = e_flush;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         check("IF_ID_PC", IF_ID_PC, e.pc);
         check("IF_ID_PCplus4", IF_ID_PCplus4, e.pc4);
         check("IF_ID_Instr", IF_ID_Instr, e.instr);
         check("IF_ID_Valid", 32'(IF_ID_Valid), 32'(e.valid));
         check("EPC", EPC, e.epc);
         check("StallCnt", 32'(StallCnt), 32'(e.stall));
         check("FlushCnt", 32'(FlushCnt), 32'(e.flush));
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic [31:0] pc, input logic [31:0] instr);
      IF_PC = pc; IF_Instr = instr;
      ID_EX_MemRead = 1'b0; ID_EX_Rt = 5'd0; EX_BranchTaken = 1'b0; irq = 1'b0;
   endtask

   task automatic check_reset_values();
      check("rst_PC", IF_ID_PC, 32'h8000_0000);
      check("rst_PCplus4", IF_ID_PCplus4, 32'h0);
      check("rst_Instr", IF_ID_Instr, 32'h0);
      check("rst_Valid", 32'(IF_ID_Valid), 32'h0);
      check("rst_EPC", EPC, 32'h0);
      check("rst_StallCnt", 32'(StallCnt), 32'h0);
      check("rst_FlushCnt", 32'(FlushCnt), 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      idle(32'h0, 32'h0);
      #2;
      check_reset_values();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Normal fetch, then kernel-bit preservation on PC+4 wrap
      idle(32'h0000_0010, 32'h2008_0005); comb(1, 0, 0);
      nxt(32'h10, 32'h14, 32'h2008_0005, 1); tick();
      idle(32'hFFFF_FFFC, 32'h0); comb(1, 0, 0);
      nxt(32'hFFFF_FFFC, 32'h8000_0000, 32'h0, 1); tick();

      // Load-use stall and Rt=0 exemption
      idle(32'h20, 32'h0109_5020); comb(1, 0, 0);
      nxt(32'h20, 32'h24, 32'h0109_5020, 1); tick();
      idle(32'h24, 32'h0); ID_EX_MemRead = 1; ID_EX_Rt = 5'd8; comb(0, 1, 0);
      e_stall = 16'd1; nxt(32'h20, 32'h24, 32'h0109_5020, 1); tick();
      idle(32'h24, 32'h0109_5020); ID_EX_MemRead = 1; ID_EX_Rt = 5'd0; comb(1, 0, 0);
      nxt(32'h24, 32'h28, 32'h0109_5020, 1); tick();

      // Branch beats a coincident load-use
      idle(32'h28, 32'h0); ID_EX_MemRead = 1; ID_EX_Rt = 5'd9; EX_BranchTaken = 1; comb(1, 1, 0);
      e_flush = 16'd1; nxt(32'h0, 32'h0, 32'h0, 0); tick();
      idle(32'h40, 32'h0); ID_EX_MemRead = 1; ID_EX_Rt = 5'd9; comb(1, 0, 0);
      nxt(32'h40, 32'h44, 32'h0, 1); tick();

      // User-mode interrupt from a one-cycle pulse
      idle(32'h40, 32'h0); irq = 1; comb(1, 0, 0);
      nxt(32'h40, 32'h44, 32'h0, 1); tick();
      idle(32'h44, 32'h0); comb(1, 1, 1);
      e_epc = 32'h40; e_flush = 16'd2; nxt(32'h0, 32'h0, 32'h0, 0); tick();
      idle(32'h50, 32'h0); comb(1, 0, 0);
      nxt(32'h50, 32'h54, 32'h0, 1); tick();

      // Kernel-mode instructions defer a pending request
      idle(32'h8000_0040, 32'h0); irq = 1; comb(1, 0, 0);
      nxt(32'h8000_0040, 32'h8000_0044, 32'h0, 1); tick();
      idle(32'h8000_0044, 32'h0); comb(1, 0, 0);
      nxt(32'h8000_0044, 32'h8000_0048, 32'h0, 1); tick();
      idle(32'h60, 32'h0); comb(1, 0, 0);
      nxt(32'h60, 32'h64, 32'h0, 1); tick();
      // irq coinciding with acceptance keeps a request pending
      idle(32'h64, 32'h0); irq = 1; comb(1, 1, 1);
      e_epc = 32'h60; e_flush = 16'd3; nxt(32'h0, 32'h0, 32'h0, 0); tick();
      idle(32'h70, 32'h0); comb(1, 0, 0);
      nxt(32'h70, 32'h74, 32'h0, 1); tick();
      idle(32'h74, 32'h0); comb(1, 1, 1);
      e_epc = 32'h70; e_flush = 16'd4; nxt(32'h0, 32'h0, 32'h0, 0); tick();

      // Jumps: j and jr discard the following slot without an ID/EX flush
      idle(32'h80, 32'h0800_0100); comb(1, 0, 0);
      nxt(32'h80, 32'h84, 32'h0800_0100, 1); tick();
      idle(32'h84, 32'h0); comb(1, 0, 0);
      e_flush = 16'd5; nxt(32'h0, 32'h0, 32'h0, 0); tick();
      idle(32'h88, 32'h03E0_0008); comb(1, 0, 0);
      nxt(32'h88, 32'h8C, 32'h03E0_0008, 1); tick();
      idle(32'h8C, 32'h0); comb(1, 0, 0);
      e_flush = 16'd6; nxt(32'h0, 32'h0, 32'h0, 0); tick();

      // Reset during a stall with an interrupt pending
      idle(32'h8000_0090, 32'h0109_5020); irq = 1; comb(1, 0, 0);
      nxt(32'h8000_0090, 32'h8000_0094, 32'h0109_5020, 1); tick();
      idle(32'hA0, 32'h0); ID_EX_MemRead = 1; ID_EX_Rt = 5'd9; comb(0, 1, 0);
      e_stall = 16'd2; nxt(32'h8000_0090, 32'h8000_0094, 32'h0109_5020, 1); tick();
      #2;
      reset = 1'b1;
      #1;
      check_reset_values();
      check("rst_PCWrite", 32'(PCWrite), 32'h1);
      @(negedge clk);
      reset = 1'b0;
      e_epc = '0; e_stall = '0; e_flush = '0;
      idle(32'hA0, 32'h0); comb(1, 0, 0);
      nxt(32'hA0, 32'hA4, 32'h0, 1); tick();
      idle(32'hA4, 32'h0); comb(1, 0, 0);
      nxt(32'hA4, 32'hA8, 32'h0, 1); tick();

      // FlushCnt saturation, then a jump at the ceiling
      idle(32'hB0, 32'h0); EX_BranchTaken = 1;
      repeat (65535) @(negedge clk);
      EX_BranchTaken = 0;
      #1;
      check("FlushCnt_sat", 32'(FlushCnt), 32'h0000_FFFF);
      e_flush = 16'hFFFF;
      idle(32'hB0, 32'h0800_0100); comb(1, 0, 0);
      nxt(32'hB0, 32'hB4, 32'h0800_0100, 1); tick();
      idle(32'hB4, 32'h0); comb(1, 0, 0);
      nxt(32'h0, 32'h0, 32'h0, 0); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
